// File: rtl/rs_gf_pkg.sv
// GF(2^8) arithmetic and RS(16,8) generator constants shared by the
// Reed-Solomon encoder and decoder blocks.
package rs_gf_pkg;

  localparam int         GF_BW   = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int         RS_P    = 8;

  // Generator coefficients g(x) = prod(x + alpha^i), i=0..7. Index k is the x^k
  // coefficient. The x^8 term is monic.
  localparam logic [RS_P-1:0][GF_BW-1:0] RS_GEN = {
    8'hff, 8'h0b, 8'h51, 8'h36, 8'hef, 8'had, 8'hc8, 8'h18
  };

  typedef enum logic {ST_MSG, ST_PAR} enc_state_e;

  typedef struct packed {
    logic [GF_BW-1:0] data;
    logic             sop;
    logic             eop;
  } rs_sym_t;

  function automatic logic [GF_BW-1:0] gf_xtime(input logic [GF_BW-1:0] a);
    return {a[GF_BW-2:0], 1'b0} ^ (a[GF_BW-1] ? GF_POLY[GF_BW-1:0] : '0);
  endfunction

  // With a constant c, this collapses to a fixed XOR network.
  function automatic logic [GF_BW-1:0] gf_mul_const(input logic [GF_BW-1:0] a,
                                                    input logic [GF_BW-1:0] c);
    logic [GF_BW-1:0] acc;
    logic [GF_BW-1:0] t;
    acc = '0;
    t   = a;
    for (int i = 0; i < GF_BW; i++) begin
      if (c[i]) acc = acc ^ t;
      t = gf_xtime(t);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_enc_16_8_if.sv
// Streaming handshake bundle for the RS(16,8) encoder: message in, codeword out.
interface rs_enc_16_8_if #(parameter int SYM_BW = 8);
  logic              in_valid;
  logic              in_ready;
  logic [SYM_BW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SYM_BW-1:0] out_data;
  logic              out_sop;
  logic              out_eop;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/rs_enc_lfsr.sv
// 8-stage RS parity register: divides m(x)*x^8 by g(x). Stage 7 holds the
// highest-degree remainder coefficient.
module rs_enc_lfsr
  import rs_gf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clr,
  input  logic [GF_BW-1:0] i_data,
  output logic [GF_BW-1:0] o_msb
);

  logic [RS_P-1:0][GF_BW-1:0] r_stg;
  logic [RS_P-1:0][GF_BW-1:0] w_nxt_ld;
  logic [GF_BW-1:0]           w_fb;

  assign w_fb  = i_data ^ r_stg[RS_P-1];
  assign o_msb = r_stg[RS_P-1];

  genvar g;
  generate
    for (g = 0; g < RS_P; g++) begin : g_stg
      if (g == 0) begin : g_lo
        assign w_nxt_ld[g] = gf_mul_const(w_fb, RS_GEN[g]);
      end else begin : g_hi
        assign w_nxt_ld[g] = r_stg[g-1] ^ gf_mul_const(w_fb, RS_GEN[g]);
      end
    end
  endgenerate

  // Clear wins so the register is empty for the next codeword regardless of shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_stg <= '0;
    else if (i_clr)   r_stg <= '0;
    else if (i_load)  r_stg <= w_nxt_ld;
    else if (i_shift) r_stg <= {r_stg[RS_P-2:0], {GF_BW{1'b0}}};
  end

endmodule

// File: rtl/rs_enc_16_8.sv
// Systematic RS(16,8) encoder over GF(256): passes 8 message symbols through,
// then emits 8 parity symbols. Single-register output stage with backpressure.
module rs_enc_16_8
  import rs_gf_pkg::*;
#(
  parameter int SYM_BW = 8,
  parameter int N_SYM  = 16,
  parameter int K_SYM  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rs_enc_16_8_if.slave bus
);

  localparam int P_SYM = N_SYM - K_SYM;
  localparam int CNT_W = $clog2(K_SYM);
  localparam logic [CNT_W-1:0] LAST_M = CNT_W'(K_SYM - 1);
  localparam logic [CNT_W-1:0] LAST_P = CNT_W'(P_SYM - 1);

  enc_state_e        r_st, w_st_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  rs_sym_t           r_out;
  logic              r_out_valid;

  logic              w_free;
  logic              w_in_ready;
  logic              w_acc;
  logic              w_par_ld;
  logic              w_ld, w_sh, w_clr;
  logic [SYM_BW-1:0] w_par;

  assign w_free     = !r_out_valid || bus.out_ready;
  assign w_in_ready = (r_st == ST_MSG) && w_free;
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_par_ld   = (r_st == ST_PAR) && w_free;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out.data;
  assign bus.out_sop   = r_out.sop;
  assign bus.out_eop   = r_out.eop;

  rs_enc_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ld),
    .i_shift (w_sh),
    .i_clr   (w_clr),
    .i_data  (bus.in_data),
    .o_msb   (w_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= ST_MSG;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    w_ld      = 1'b0;
    w_sh      = 1'b0;
    w_clr     = 1'b0;
    case (r_st)
      ST_MSG: begin
        if (w_acc) begin
          w_ld = 1'b1;
          if (r_cnt == LAST_M) begin
            w_st_nxt  = ST_PAR;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (w_par_ld) begin
          if (r_cnt == LAST_P) begin
            w_clr     = 1'b1;
            w_st_nxt  = ST_MSG;
            w_cnt_nxt = '0;
          end else begin
            w_sh      = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_st_nxt  = ST_MSG;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Output stage holds everything while stalled; drains to idle when free and unloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      r_out.data  <= bus.in_data;
      r_out.sop   <= (r_cnt == '0);
      r_out.eop   <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (w_par_ld) begin
      r_out.data  <= w_par;
      r_out.sop   <= 1'b0;
      r_out.eop   <= (r_cnt == LAST_P);
      r_out_valid <= 1'b1;
    end else if (w_free) begin
      r_out.sop   <= 1'b0;
      r_out.eop   <= 1'b0;
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_enc_16_8.sv
// Randomized bench for rs_enc_16_8: polynomial-division reference model,
// scoreboard, hold-while-stalled checks and syndrome checks on every codeword.
module tb_rs_enc_16_8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_enc_16_8_if #(.SYM_BW(8)) bus();

  rs_enc_16_8 #(.SYM_BW(8), .N_SYM(16), .K_SYM(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  logic [7:0] msg_q[$];
  exp_t       exp_q[$];
  logic [7:0] obs[$];
  logic [7:0] gen_hi[9];
  bit         log_en;
  bit         log_rdy[$];
  bit         log_vld[$];
  bit         stall_prv;
  logic [7:0] stall_d;
  logic       stall_s, stall_e;
  int         p_in  = 100;
  int         p_out = 100;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Carry-less product then reduction modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011D << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] apow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic build_gen();
    logic [7:0] lo[9];
    logic [7:0] nw[9];
    logic [7:0] rt;
    for (int j = 0; j < 9; j++) lo[j] = 8'h00;
    lo[0] = 8'h01;
    for (int i = 0; i < 8; i++) begin
      rt = apow(i);
      for (int j = 0; j < 9; j++) nw[j] = ((j > 0) ? lo[j-1] : 8'h00) ^ gmul(rt, lo[j]);
      for (int j = 0; j < 9; j++) lo[j] = nw[j];
    end
    for (int k = 0; k < 9; k++) gen_hi[k] = lo[8-k];
  endtask

  task automatic push_word(input logic [63:0] m, input bit fixed, input logic [63:0] fpar);
    logic [7:0] r[16];
    logic [7:0] c;
    exp_t       e;
    for (int i = 0; i < 8; i++) begin
      r[i]   = m[63-8*i -: 8];
      r[8+i] = 8'h00;
      msg_q.push_back(r[i]);
      e.d = r[i]; e.sop = (i == 0); e.eop = 1'b0;
      exp_q.push_back(e);
    end
    for (int j = 0; j < 8; j++) begin
      c = r[j];
      for (int k = 1; k < 9; k++) r[j+k] = r[j+k] ^ gmul(c, gen_hi[k]);
    end
    for (int i = 0; i < 8; i++) begin
      e.d   = fixed ? fpar[63-8*i -: 8] : r[8+i];
      e.sop = 1'b0;
      e.eop = (i == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_syndromes();
    logic [7:0] s, ai;
    for (int i = 0; i < 8; i++) begin
      ai = apow(i);
      s  = 8'h00;
      foreach (obs[j]) s = gmul(s, ai) ^ obs[j];
      chk($sformatf("syndrome%0d", i), s, 0);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (msg_q.size() > 0 && $urandom_range(99) < p_in) begin
      bus.in_valid = 1'b1;
      bus.in_data  = msg_q[0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
    end
    bus.out_ready = ($urandom_range(99) < p_out);
    #4;
    if (log_en) begin
      log_rdy.push_back(bus.in_ready);
      log_vld.push_back(bus.out_valid);
    end
    if (stall_prv) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, stall_d);
      chk("hold_sop", bus.out_sop, stall_s);
      chk("hold_eop", bus.out_eop, stall_e);
    end
    stall_prv = bus.out_valid && !bus.out_ready;
    stall_d   = bus.out_data;
    stall_s   = bus.out_sop;
    stall_e   = bus.out_eop;
    if (bus.in_valid && bus.in_ready) void'(msg_q.pop_front());
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_sop", bus.out_sop, e.sop);
        chk("out_eop", bus.out_eop, e.eop);
      end
      obs.push_back(bus.out_data);
      if (bus.out_eop) begin
        chk("cw_len", obs.size(), 16);
        check_syndromes();
        obs.delete();
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((msg_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int lo_a, lo_b, vcnt, n;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    stall_prv     = 1'b0;
    log_en        = 1'b0;
    build_gen();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sop", bus.out_sop, 0);
    chk("rst_eop", bus.out_eop, 0);
    chk("rst_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_valid", bus.out_valid, 0);

    // All-zero message, then the x^0 impulse against the published parity
    p_in = 100; p_out = 100;
    push_word(64'h0, 1'b0, 64'h0);
    drain(200);
    push_word(64'h0000_0000_0000_0001, 1'b1, 64'hff0b_5136_efad_c818);
    drain(200);

    // Two back-to-back codewords at full rate
    log_rdy.delete(); log_vld.delete();
    log_en = 1'b1;
    push_word({$urandom, $urandom}, 1'b0, 64'h0);
    push_word({$urandom, $urandom}, 1'b0, 64'h0);
    repeat (40) step();
    log_en = 1'b0;
    vcnt = 0; lo_a = 0; lo_b = 0;
    for (int i = 1; i <= 32; i++) vcnt += int'(log_vld[i]);
    for (int i = 0; i < 16; i++) lo_a += int'(!log_rdy[i]);
    for (int i = 16; i < 32; i++) lo_b += int'(!log_rdy[i]);
    chk("b2b_valid_cycles", vcnt, 32);
    chk("b2b_valid_after", log_vld[33], 0);
    chk("b2b_ready_low_cw0", lo_a, 8);
    chk("b2b_ready_low_cw1", lo_b, 8);
    chk("b2b_ready_par_start", log_rdy[8], 0);
    chk("b2b_ready_gapfree", log_rdy[16], 1);
    drain(100);

    // Random traffic in batches with varying throttle
    for (int b = 0; b < 10; b++) begin
      p_in  = $urandom_range(40, 100);
      p_out = $urandom_range(40, 100);
      for (int w = 0; w < 100; w++) push_word({$urandom, $urandom}, 1'b0, 64'h0);
      drain(20000);
    end

    // Reset after the 3rd parity symbol is consumed
    p_in = 100; p_out = 100;
    push_word({$urandom, $urandom}, 1'b0, 64'h0);
    n = 0;
    while (exp_q.size() > 5 && n < 100) begin
      step();
      n++;
    end
    chk("mid_rst_reach", exp_q.size(), 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_sop", bus.out_sop, 0);
    chk("mid_rst_eop", bus.out_eop, 0);
    msg_q.delete(); exp_q.delete(); obs.delete();
    stall_prv    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("mid_rst_ready", bus.in_ready, 1);
    repeat (3) step();
    chk("mid_rst_quiet", bus.out_valid, 0);
    push_word({$urandom, $urandom}, 1'b0, 64'h0);
    drain(200);
    push_word(64'h0000_0000_0000_0001, 1'b1, 64'hff0b_5136_efad_c818);
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_enc_16_8.md
RS_ENC_16_8 -- requirements
Module: rs_enc_16_8

Interface
REQ-001 Parameter SYM_BW, default 8: symbol width (GF(2^8)); other values are not supported.
REQ-002 Parameter N_SYM, default 16: codeword length in symbols.
REQ-003 Parameter K_SYM, default 8: message length in symbols; parity count is P=N_SYM-K_SYM=8 (t=4).
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  message symbol valid.
REQ-007 in_ready  output  1  encoder can accept a message symbol.
REQ-008 in_data  input  SYM_BW  message symbol; highest-degree symbol first.
REQ-009 out_valid  output  1  codeword symbol valid.
REQ-010 out_ready  input  1  downstream accepts a codeword symbol.
REQ-011 out_data  output  SYM_BW  codeword symbol; 8 message symbols, then 8 parity symbols, highest degree first.
REQ-012 out_sop / out_eop  output  1 each  high with codeword symbol 0 / symbol 15.

Function
REQ-013 The code SHALL be systematic RS(16,8) over GF(256), primitive polynomial 0x11D, alpha=0x02, generator g(x)=prod_{i=0..7}(x+alpha^i) = 01 ff 0b 51 36 ef ad c8 18 (x^8..x^0).
REQ-014 Parity SHALL be the coefficients of m(x)*x^8 mod g(x).
REQ-015 The output stage SHALL be a single register; it is free when !out_valid || out_ready.
REQ-016 The FSM SHALL have two states. MSG accepts message symbols. PAR emits parity.
REQ-017 in_ready SHALL equal (state==MSG) && (output stage free); it SHALL be combinational from registered state and out_ready only.
REQ-018 On each in_valid&&in_ready, the block SHALL:
- load in_data into out_data with out_valid=1 on the next edge;
- update the 8-stage LFSR with feedback = in_data XOR stage7;
- increment the symbol counter (0..7).
REQ-019 Latency from input acceptance to out_valid SHALL be exactly 1 cycle; out_sop SHALL accompany message symbol 0.
REQ-020 On acceptance of message symbol 7, the state SHALL go to PAR and the counter SHALL clear.
REQ-021 In PAR, on each cycle the output stage is free, the block SHALL:
- load LFSR stage7 into out_data with out_valid=1;
- shift the LFSR toward stage7 with zero fill;
- increment the counter.
REQ-022 The 8th parity load SHALL assert out_eop, return the state to MSG and clear the LFSR.
REQ-023 In MSG, a message symbol SHALL be acceptable in the same cycle the 8th parity is consumed, giving gap-free back-to-back codewords (16 output cycles per codeword at full rate).
REQ-024 While out_valid && !out_ready, out_data/out_sop/out_eop SHALL hold stable, and the LFSR and counter SHALL not change.
REQ-025 When the output stage is free and no load occurs, out_valid SHALL fall to 0 on the next edge.
REQ-026 in_valid low in mid-message SHALL stall the encoder without corrupting state; no timeout.

Reset
REQ-027 Asserting rst_n low, at any time including mid-codeword, SHALL immediately set:
- out_valid=0, out_sop=0, out_eop=0, out_data=0;
- state=MSG, counter=0, LFSR=0.
REQ-028 The partial codeword SHALL be discarded with no further symbols emitted.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n deasserts, given out_valid=0.

Structure
REQ-030 The GF(256) constants (0x11D, generator coefficients) and the GF multiply-by-constant function SHALL live in a shared package rs_gf_pkg, also used by the decoder blocks.
REQ-031 Multipliers SHALL be constant-coefficient XOR networks; no EXP/LOG tables.
REQ-032 One sub-module is natural: rs_enc_lfsr, the 8-stage parity register with load/shift/clear controls.

Verification
REQ-033 All-zero message -> 16 zero symbols, sop on symbol 0, eop on symbol 15.
REQ-034 Message 00 00 00 00 00 00 00 01 -> parity ff 0b 51 36 ef ad c8 18.
REQ-035 Two back-to-back codewords with out_ready=1 and in_valid=1 throughout -> 32 consecutive out_valid cycles, in_ready low for exactly the 8 parity cycles of each codeword.
REQ-036 Random out_ready and in_valid over 1000 random messages -> output matches the software model, and each output symbol is held while stalled.
REQ-037 rst_n pulsed after the 3rd parity symbol -> out_valid=0 immediately; the next message encodes correctly from symbol 0.
REQ-038 Encoder output fed to the decoder syndrome block -> all 8 syndromes zero, and KES produces lamda=1.
